fifo: RTL and testbench
=======================

# fifo

Synchronous first-word-fall-through FIFO used by the VGA read path to queue the SDRAM addresses of outstanding read requests. The head entry is always visible on `dout`, so the consumer can compare it against returning read data and pop it in the same cycle. Width and depth are parameters. Status flags are registered.

## Interface
- `DBITS`, default 8: data width in bits. The VGA master instantiates it with 26.
- `ABITS`, default 5: address width. Depth `DEPTH = 2**ABITS`, so the default is 32 entries.
- `clk` in, 1: clock. All state changes on the rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `wr` in, 1: push `din` this cycle.
- `rd` in, 1: pop the head entry this cycle.
- `din` in, DBITS: write data.
- `dout` out, DBITS: head entry (oldest unread). It is 0 while `empty`=1.
- `full` out, 1: count == DEPTH.
- `empty` out, 1: count == 0.
- `almost_full` out, 1: count >= DEPTH-1.
- `almost_empty` out, 1: count <= 1.

## Operation
- Storage is a DEPTH x DBITS array with no reset.
- Write pointer `wp`, read pointer `rp`: ABITS bits each, wrap modulo DEPTH.
- Occupancy `count`: ABITS+1 bits.
- Effective operations:
  - `do_wr = wr && (!full || rd)`
  - `do_rd = rd && !empty`
- `do_wr`: store `din` at `mem[wp]` and increment `wp`.
- `do_rd`: increment `rp`.
- Count update:
  - `count` += 1 on `do_wr && !do_rd`.
  - `count` -= 1 on `do_rd && !do_wr`.
  - Otherwise `count` is unchanged.
- Boundary rules:
  - Write while full with no read: dropped, no state change.
  - Read while empty: ignored, pointers unchanged.
  - Write + read while empty: the write happens, the read is ignored, and count becomes 1.
  - Write + read while full: both happen and count stays DEPTH.
  - Write + read at any other level: both happen and count is unchanged.
- `dout` is combinational from `mem[rp]`, gated to 0 when `empty`.
- Flags `full`, `empty`, `almost_full`, `almost_empty` are registered and computed from the next value of `count`. They are therefore exact in the cycle after each edge.
- `reset` low, at any time including mid-operation:
  - `wp`, `rp` and `count` go to 0.
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, so `dout`=0.
  - Memory contents are don't-care.
  - Queued data is discarded.

## Timing
- Write-to-read latency: a word written at edge N appears on `dout` after edge N, and `empty` deasserts after the same edge.
- Read latency: zero. `dout` is valid in the same cycle `rd` is asserted.
- The pop takes effect at that cycle's edge, after which `dout` shows the next entry.
- Simultaneous write and read when count==1: the newly written word appears on `dout` after the edge.
- No combinational path from `wr`/`din` to `dout` or to the flags in the same cycle.
- One push and/or one pop per cycle, sustained indefinitely.

## Structure
- No shared package is required. `DEPTH` is a localparam derived from `ABITS`.
- One natural sub-module, `fifo_ctrl`, holds the pointers, count, effective-operation logic and registered flags.
- The top-level `fifo` holds the storage array and the `dout` mux.

## Test plan
- Reset then idle:
  - Expect `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `dout`=0.
  - Assert `rd` for 3 cycles and expect no change.
- Order: with DBITS=26, push 0x100, 0x108, 0x110 on consecutive cycles.
  - `dout`=0x100 after the first edge.
  - Pop three times: `dout` reads 0x100, 0x108, 0x110, then `empty`=1 and `dout`=0.
- Fill to DEPTH=32 with values 0..31:
  - `almost_full` rises at count 31 and `full` at 32.
  - An extra write of 99 is dropped.
  - Draining returns 0..31 exactly, and `almost_empty` rises at count 1.
- Simultaneous write and read:
  - When full: push 77 and pop. Head 0 is popped, count stays 32, `full` stays 1, and 77 emerges last.
  - When empty: push 5 and pop. Count becomes 1 and `dout`=5.
- Wrap-around: run 100 cycles of random push/pop at 50% each against a reference queue. Data and flags must match every cycle, with pointers wrapping several times.
- Mid-operation reset: with count 10, pull `reset` low asynchronously between edges.
  - Flags go to reset values immediately and `dout`=0.
  - After release, push 42; expect `dout`=42 and count 1.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg : operation encoding shared by the FIFO top and its controller
// rev 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic do_wr, input logic do_rd);
    return fifo_op_e'({do_rd, do_wr});
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_ctrl : pointers, occupancy count, effective ops and registered flags
// rev 1.0
// ---------------------------------------------------------------------------
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ABITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  output logic             do_wr,
  output logic [ABITS-1:0] wp,
  output logic [ABITS-1:0] rp,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int DEPTH = 2 ** ABITS;
  localparam logic [ABITS-1:0] c_PTR_ONE   = 1;
  localparam logic [ABITS:0]   c_CNT_ONE   = 1;
  localparam logic [ABITS:0]   c_CNT_FULL  = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0]   c_CNT_AFULL = (ABITS+1)'(DEPTH - 1);

  logic [ABITS-1:0] r_wp;
  logic [ABITS-1:0] r_rp;
  logic [ABITS:0]   r_count;
  logic [ABITS:0]   w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             w_do_wr;
  logic             w_do_rd;
  fifo_op_e         w_op;

  // A read frees the head slot at this edge, so a write may proceed while full.
  assign w_do_wr = wr && (!r_full || rd);
  assign w_do_rd = rd && !r_empty;
  assign w_op    = fifo_op(w_do_wr, w_do_rd);

  always_comb begin
    w_count_nxt = r_count;
    case (w_op)
      OP_PUSH: w_count_nxt = r_count + c_CNT_ONE;
      OP_POP:  w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp           <= '0;
      r_rp           <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_do_wr) r_wp <= r_wp + c_PTR_ONE;
      if (w_do_rd) r_rp <= r_rp + c_PTR_ONE;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == c_CNT_FULL);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= c_CNT_AFULL);
      r_almost_empty <= (w_count_nxt <= c_CNT_ONE);
    end
  end

  assign do_wr        = w_do_wr;
  assign wp           = r_wp;
  assign rp           = r_rp;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;

endmodule
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo : first-word-fall-through FIFO, storage array and gated head output
// rev 1.0
// ---------------------------------------------------------------------------
module fifo
  import fifo_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int ABITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int DEPTH = 2 ** ABITS;

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [ABITS-1:0] w_wp;
  logic [ABITS-1:0] w_rp;
  logic             w_do_wr;
  logic             w_empty;

  fifo_ctrl #(
    .ABITS (ABITS)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .do_wr        (w_do_wr),
    .wp           (w_wp),
    .rp           (w_rp),
    .full         (full),
    .empty        (w_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[w_wp] <= din;
  end

  // Unreset storage may hold stale data; gate it off while empty.
  assign dout  = w_empty ? '0 : r_mem[w_rp];
  assign empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// tb_fifo : directed and reference-queue checks of the FWFT FIFO (DBITS=26).
module tb_fifo;

  localparam int DBITS = 26;
  localparam int ABITS = 5;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr;
  logic             rd;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;

  int checks = 0;
  int errors = 0;
  logic [DBITS-1:0] q[$];

  fifo #(
    .DBITS (DBITS),
    .ABITS (ABITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_model(input string tag);
    int n;
    logic [DBITS-1:0] head;
    n    = q.size();
    head = (n == 0) ? '0 : q[0];
    check({tag, ".dout"},  32'(dout), 32'(head));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"},  32'(full), 32'(n == DEPTH));
    check({tag, ".afull"}, 32'(almost_full), 32'(n >= DEPTH - 1));
    check({tag, ".aempty"},32'(almost_empty), 32'(n <= 1));
  endtask

  // One clock cycle with the given inputs; updates the reference queue.
  task automatic cyc(input logic w, input logic r, input logic [DBITS-1:0] d);
    logic mw, mr;
    wr  = w;
    rd  = r;
    din = d;
    mw  = w && ((q.size() < DEPTH) || r);
    mr  = r && (q.size() > 0);
    @(posedge clk);
    if (mr) void'(q.pop_front());
    if (mw) q.push_back(d);
    #1;
    wr  = 1'b0;
    rd  = 1'b0;
    din = '0;
  endtask

  initial begin
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst.empty",  32'(empty), 32'd1);
    check("rst.aempty", 32'(almost_empty), 32'd1);
    check("rst.full",   32'(full), 32'd0);
    check("rst.afull",  32'(almost_full), 32'd0);
    check("rst.dout",   32'(dout), 32'd0);

    // Reads while empty are ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, '0);
      check("idle_rd.empty", 32'(empty), 32'd1);
      check("idle_rd.dout",  32'(dout), 32'd0);
    end

    // Order
    cyc(1'b1, 1'b0, 26'h100);
    check("ord.first", 32'(dout), 32'h100);
    check("ord.empty", 32'(empty), 32'd0);
    cyc(1'b1, 1'b0, 26'h108);
    cyc(1'b1, 1'b0, 26'h110);
    check("ord.head0", 32'(dout), 32'h100);
    cyc(1'b0, 1'b1, '0);
    check("ord.head1", 32'(dout), 32'h108);
    cyc(1'b0, 1'b1, '0);
    check("ord.head2", 32'(dout), 32'h110);
    check("ord.aempty", 32'(almost_empty), 32'd1);
    cyc(1'b0, 1'b1, '0);
    check("ord.empty_end", 32'(empty), 32'd1);
    check("ord.dout_end",  32'(dout), 32'd0);

    // Fill 0..31
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, DBITS'(i));
      check("fill.afull", 32'(almost_full), 32'(i + 1 >= 31));
      check("fill.full",  32'(full), 32'(i + 1 == 32));
    end
    cyc(1'b1, 1'b0, 26'd99);
    check("drop.full", 32'(full), 32'd1);
    check("drop.head", 32'(dout), 32'd0);

    // Simultaneous push/pop while full
    cyc(1'b1, 1'b1, 26'd77);
    check("fullrw.full", 32'(full), 32'd1);
    check("fullrw.head", 32'(dout), 32'd1);

    // Drain: 1..31 then 77
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain.data", 32'(dout), (i == DEPTH) ? 32'd77 : 32'(i));
      cyc(1'b0, 1'b1, '0);
      check("drain.aempty", 32'(almost_empty), 32'(DEPTH - i <= 1));
      check("drain.full",   32'(full), 32'd0);
    end
    check("drain.empty", 32'(empty), 32'd1);
    check("drain.dout",  32'(dout), 32'd0);

    // Simultaneous push/pop while empty
    cyc(1'b1, 1'b1, 26'd5);
    check("emptyrw.dout",   32'(dout), 32'd5);
    check("emptyrw.empty",  32'(empty), 32'd0);
    check("emptyrw.aempty", 32'(almost_empty), 32'd1);

    // Random traffic against the reference queue
    for (int i = 0; i < 100; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DBITS'($urandom));
      check_model("rand");
    end

    // Drain, then queue ten entries
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (q.size() != 0) cyc(1'b0, 1'b1, '0);
    end
    check("predrain.empty", 32'(empty), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, DBITS'(200 + i));
    check("pre_rst.head", 32'(dout), 32'd200);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check("arst.empty",  32'(empty), 32'd1);
    check("arst.aempty", 32'(almost_empty), 32'd1);
    check("arst.full",   32'(full), 32'd0);
    check("arst.afull",  32'(almost_full), 32'd0);
    check("arst.dout",   32'(dout), 32'd0);
    q.delete();
    #2;
    reset = 1'b1;
    cyc(1'b1, 1'b0, 26'd42);
    check("post_rst.dout",   32'(dout), 32'd42);
    check("post_rst.empty",  32'(empty), 32'd0);
    check("post_rst.aempty", 32'(almost_empty), 32'd1);
    cyc(1'b0, 1'b1, '0);
    check("post_rst.count1", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
